// File: rtl/inst_rom_responder_pkg.sv
// -----------------------------------------------------------------------------
// inst_rom_responder_pkg
// Shared types and constants for the instruction-fetch responder.
//   inst_bus_t / inst_addr_bus_t : 32-bit instruction word and byte address
//   ZERO_WORD / NOP_INST         : blank response and NOP encoding (both 0)
//   WAIT_CNT_W / wait_cnt_t      : wait-state down-counter width (0..15)
//   state_e                      : responder FSM states
// -----------------------------------------------------------------------------
package inst_rom_responder_pkg;

  typedef logic [31:0] inst_bus_t;
  typedef logic [31:0] inst_addr_bus_t;

  localparam inst_bus_t ZERO_WORD = 32'h0000_0000;
  localparam inst_bus_t NOP_INST  = 32'h0000_0000;

  localparam int unsigned WAIT_CNT_W = 4;
  typedef logic [WAIT_CNT_W-1:0] wait_cnt_t;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  // The counter holds the stall cycles still to come after the accept cycle,
  // so a fetch with N wait states loads N-1 and delivers when it reads 0.
  function automatic wait_cnt_t wait_load(input int unsigned wait_cycles);
    if (wait_cycles == 0) begin
      return '0;
    end
    return wait_cnt_t'(wait_cycles - 1);
  endfunction

endpackage

// File: rtl/inst_mem_array.sv
// -----------------------------------------------------------------------------
// inst_mem_array
// DEPTH x 32 instruction store with one write port and one registered,
// read-first read port. Contents are not reset; they are filled through the
// boot-load write port.
//   clk        : system clock
//   we_i       : write strobe
//   wr_addr_i  : write word index
//   wr_data_i  : write data
//   rd_en_i    : capture mem[rd_addr_i] into the read register this edge
//   rd_addr_i  : read word index
//   rd_data_o  : read register (holds while rd_en_i is low)
// -----------------------------------------------------------------------------
module inst_mem_array
  import inst_rom_responder_pkg::*;
#(
  parameter int unsigned DEPTH  = 1024,
  parameter int unsigned ADDR_W = 10
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  inst_bus_t         wr_data_i,
  input  logic              rd_en_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output inst_bus_t         rd_data_o
);

  inst_bus_t mem_q [DEPTH];
  inst_bus_t rd_data_q;

  // Both accesses on the same edge with nonblocking updates: a read of the
  // word being written returns the old contents.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
    if (rd_en_i) begin
      rd_data_q <= mem_q[rd_addr_i];
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/inst_rom_responder.sv
// -----------------------------------------------------------------------------
// inst_rom_responder
// Responder side of the instruction-fetch interface: registered read from a
// word-organised store, optional wait states with a stall request back to the
// pipeline, and a boot-load write port.
//   clk, rst    : system clock; asynchronous active-high reset
//   rom_en_in   : fetch request enable
//   addr        : fetch byte address, word index = addr[ADDR_W+1:2]
//   inst        : returned instruction word
//   inst_valid  : inst carries the response to an accepted request
//   stall_req   : freeze PC/IF while wait states run (combinational)
//   load_we/load_addr/load_data : boot-load write port
//   addr_err    : only with INST_ROM_ALIGN_CHECK_EN; pulses with inst_valid
//                 when the fetched address was not word aligned (inst = NOP)
//
// State table
//   IDLE | no fetch in flight; an enabled request is accepted here
//   BUSY | wait states running; counter = stall cycles left, 0 = delivery
// -----------------------------------------------------------------------------
module inst_rom_responder
  import inst_rom_responder_pkg::*;
#(
  parameter int unsigned DEPTH       = 1024,
  parameter int unsigned ADDR_W      = 10,
  parameter int unsigned WAIT_CYCLES = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rom_en_in,
  input  inst_addr_bus_t    addr,
  output inst_bus_t         inst,
  output logic              inst_valid,
  output logic              stall_req,
  input  logic              load_we,
  input  logic [ADDR_W-1:0] load_addr,
  input  inst_bus_t         load_data
`ifdef INST_ROM_ALIGN_CHECK_EN
  ,
  output logic              addr_err
`endif
);

`ifdef INST_ROM_ALIGN_CHECK_EN
  localparam bit ALIGN_CHK = 1'b1;
`else
  localparam bit ALIGN_CHK = 1'b0;
`endif

  state_e            state_q, state_d;
  wait_cnt_t         cnt_q, cnt_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic              mis_q, mis_d;
  logic              valid_q, valid_d;
  logic              blank_q, blank_d;

  logic [ADDR_W-1:0] addr_idx;
  logic              addr_mis;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_idx;
  logic              rd_mis;
  inst_bus_t         rd_data;
  logic              unused_addr_hi;

  assign addr_idx       = addr[ADDR_W+1:2];
  assign addr_mis       = (addr[1:0] != 2'b00);
  assign unused_addr_hi = ^addr[31:ADDR_W+2];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    mis_d   = mis_q;
    rd_en   = 1'b0;
    rd_idx  = addr_idx;
    rd_mis  = addr_mis;

    if (!rom_en_in) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else if (WAIT_CYCLES == 0) begin
      rd_en = 1'b1;
    end else begin
      unique case (state_q)
        IDLE: begin
          state_d = BUSY;
          cnt_d   = wait_load(WAIT_CYCLES);
          idx_d   = addr_idx;
          mis_d   = addr_mis;
        end
        BUSY: begin
          if (cnt_q == '0) begin
            rd_en   = 1'b1;
            rd_idx  = idx_q;
            rd_mis  = mis_q;
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q - wait_cnt_t'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end

    valid_d = rd_en;

    // The blank flag forces ZeroWord on inst: set by a dropped request,
    // cleared by a real read (or kept for a misaligned read), held otherwise.
    blank_d = blank_q;
    if (!rom_en_in) begin
      blank_d = 1'b1;
    end else if (rd_en) begin
      blank_d = ALIGN_CHK & rd_mis;
    end
  end

  // Held low in reset so the pipeline is never frozen by a responder that
  // is being cleared.
  assign stall_req = (WAIT_CYCLES != 0) && !rst && rom_en_in &&
                     ((state_q == IDLE) || (cnt_q != '0));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      mis_q   <= 1'b0;
      valid_q <= 1'b0;
      blank_q <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      mis_q   <= mis_d;
      valid_q <= valid_d;
      blank_q <= blank_d;
    end
  end

  inst_mem_array #(
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W)
  ) u_mem (
    .clk      (clk),
    .we_i     (load_we),
    .wr_addr_i(load_addr),
    .wr_data_i(load_data),
    .rd_en_i  (rd_en),
    .rd_addr_i(rd_idx),
    .rd_data_o(rd_data)
  );

  // NOP and ZeroWord share an encoding, so one blank flag covers both.
  assign inst       = blank_q ? ZERO_WORD : rd_data;
  assign inst_valid = valid_q;

`ifdef INST_ROM_ALIGN_CHECK_EN
  logic err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= rd_en & rd_mis;
    end
  end

  assign addr_err = err_q;
`endif

endmodule

// File: tb/tb_inst_rom_responder.sv
// -----------------------------------------------------------------------------
// tb_inst_rom_responder
// Two responders side by side (no wait states, two wait states) share clock,
// reset and the boot-load port. A per-instance transaction model decides each
// cycle whether the held request stalls or delivers; delivered words are
// pushed to a queue and a separate monitor pops them on inst_valid.
// -----------------------------------------------------------------------------
module tb_inst_rom_responder;

  logic        clk;
  logic        rst;
  logic        en0, en2;
  logic [31:0] addr0, addr2;
  logic [31:0] inst0, inst2;
  logic        valid0, valid2;
  logic        stall0, stall2;
  logic        load_we;
  logic [9:0]  load_addr;
  logic [31:0] load_data;

`ifdef INST_ROM_ALIGN_CHECK_EN
  logic err0, err2;
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif

  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] ref_mem [1024];
  logic [31:0] exp_q0 [$];
  logic [31:0] exp_q2 [$];
  int          wait_of [2] = '{0, 2};
  int          rk [2];
  bit          pen [2];
  bit          pdel [2];
  bit          pmis [2];
  logic [31:0] cur_a2;

  inst_rom_responder #(.DEPTH(1024), .ADDR_W(10), .WAIT_CYCLES(0)) u_dut_w0 (
    .clk       (clk),
    .rst       (rst),
    .rom_en_in (en0),
    .addr      (addr0),
    .inst      (inst0),
    .inst_valid(valid0),
    .stall_req (stall0),
    .load_we   (load_we),
    .load_addr (load_addr),
    .load_data (load_data)
`ifdef INST_ROM_ALIGN_CHECK_EN
    ,
    .addr_err  (err0)
`endif
  );

  inst_rom_responder #(.DEPTH(1024), .ADDR_W(10), .WAIT_CYCLES(2)) u_dut_w2 (
    .clk       (clk),
    .rst       (rst),
    .rom_en_in (en2),
    .addr      (addr2),
    .inst      (inst2),
    .inst_valid(valid2),
    .stall_req (stall2),
    .load_we   (load_we),
    .load_addr (load_addr),
    .load_data (load_data)
`ifdef INST_ROM_ALIGN_CHECK_EN
    ,
    .addr_err  (err2)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // Scoreboard monitor: every inst_valid must match the oldest expected word.
  always @(negedge clk) begin
    if (!rst) begin
      if (valid0 === 1'b1) begin
        if (exp_q0.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL data0: unexpected inst_valid, inst=%h", inst0);
        end else begin
          chk("data0", inst0, exp_q0.pop_front());
        end
      end
      if (valid2 === 1'b1) begin
        if (exp_q2.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL data2: unexpected inst_valid, inst=%h", inst2);
        end else begin
          chk("data2", inst2, exp_q2.pop_front());
        end
      end
    end
  end

  // One clock of stimulus, entered and left at posedge+1.
  task automatic cycle(input bit e0_i, input logic [31:0] ad0_i,
                       input bit e2_i, input logic [31:0] ad2_i,
                       input bit we_i, input logic [9:0] wa_i, input logic [31:0] wd_i);
    bit          e [2];
    logic [31:0] ad [2];
    bit          st [2];
    bit          del [2];
    bit          mis [2];
    logic [31:0] expv;
    en0 = e0_i; addr0 = ad0_i; en2 = e2_i; addr2 = ad2_i;
    load_we = we_i; load_addr = wa_i; load_data = wd_i;
    e[0] = e0_i; e[1] = e2_i; ad[0] = ad0_i; ad[1] = ad2_i;
    for (int d = 0; d < 2; d++) begin
      st[d] = 1'b0; del[d] = 1'b0; mis[d] = 1'b0;
      if (e[d]) begin
        if (rk[d] < wait_of[d]) begin
          st[d] = 1'b1;
          rk[d]++;
        end else begin
          del[d] = 1'b1;
          rk[d]  = 0;
        end
      end else begin
        rk[d] = 0;
      end
      if (del[d]) begin
        mis[d] = ALIGN && (ad[d][1:0] != 2'b00);
        expv   = mis[d] ? 32'h0 : ref_mem[ad[d][11:2]];
        if (d == 0) exp_q0.push_back(expv);
        else        exp_q2.push_back(expv);
      end
    end
    if (we_i) ref_mem[wa_i] = wd_i;
    @(negedge clk);
    chk("stall0", {31'b0, stall0}, {31'b0, st[0]});
    chk("stall2", {31'b0, stall2}, {31'b0, st[1]});
    chk("valid0", {31'b0, valid0}, {31'b0, pdel[0]});
    chk("valid2", {31'b0, valid2}, {31'b0, pdel[1]});
    if (!pen[0]) chk("blank0", inst0, 32'h0);
    if (!pen[1]) chk("blank2", inst2, 32'h0);
`ifdef INST_ROM_ALIGN_CHECK_EN
    chk("err0", {31'b0, err0}, {31'b0, pdel[0] & pmis[0]});
    chk("err2", {31'b0, err2}, {31'b0, pdel[1] & pmis[1]});
`endif
    for (int d = 0; d < 2; d++) begin
      pen[d] = e[d]; pdel[d] = del[d]; pmis[d] = mis[d];
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 10'h0, 32'h0);
  endtask

  // Asserts reset with both fetch enables high; outputs must clear at once.
  task automatic do_reset();
    en0 = 1'b1; en2 = 1'b1; addr0 = 32'h0000_000C; addr2 = 32'h0000_0010;
    load_we = 1'b0;
    rst = 1'b1;
    #1;
    chk("rst_inst0",  inst0, 32'h0);
    chk("rst_valid0", {31'b0, valid0}, 32'h0);
    chk("rst_stall0", {31'b0, stall0}, 32'h0);
    chk("rst_inst2",  inst2, 32'h0);
    chk("rst_valid2", {31'b0, valid2}, 32'h0);
    chk("rst_stall2", {31'b0, stall2}, 32'h0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0; en0 = 1'b0; en2 = 1'b0;
    for (int d = 0; d < 2; d++) begin
      rk[d] = 0; pen[d] = 1'b0; pdel[d] = 1'b0; pmis[d] = 1'b0;
    end
    exp_q0.delete();
    exp_q2.delete();
  endtask

  task automatic rand_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      bit          e0, e2, we;
      logic [31:0] a0, a2, wd;
      logic [9:0]  wa;
      e0 = ($urandom_range(3) != 0);
      a0 = $urandom;
      if (rk[1] != 0) begin
        e2 = ($urandom_range(7) != 0);
        a2 = cur_a2;
      end else begin
        e2 = ($urandom_range(3) != 0);
        a2 = $urandom;
        cur_a2 = a2;
      end
      we = ($urandom_range(1) != 0);
      wd = $urandom;
      wa = ($urandom_range(3) == 0) ? a0[11:2] : 10'($urandom);
      cycle(e0, a0, e2, a2, we, wa, wd);
    end
  endtask

  initial begin
    rst = 1'b0; en0 = 1'b0; en2 = 1'b0; addr0 = '0; addr2 = '0;
    load_we = 1'b0; load_addr = '0; load_data = '0; cur_a2 = '0;
    for (int d = 0; d < 2; d++) begin
      rk[d] = 0; pen[d] = 1'b0; pdel[d] = 1'b0; pmis[d] = 1'b0;
    end
    #1;
    do_reset();

    for (int i = 0; i < 1024; i++) cycle(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 10'(i), $urandom);

    cycle(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 10'd3, 32'h3C01_0001);
    cycle(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 10'd4, 32'h3421_0020);

    // Back-to-back fetches, no wait states.
    cycle(1'b1, 32'h0000_000C, 1'b0, 32'h0, 1'b0, 10'h0, 32'h0);
    chk("plan_w0_first", inst0, 32'h3C01_0001);
    cycle(1'b1, 32'h0000_0010, 1'b0, 32'h0, 1'b0, 10'h0, 32'h0);
    chk("plan_w0_second", inst0, 32'h3421_0020);
    idle(1);

    // Two wait states: held for three cycles, data the cycle after.
    for (int i = 0; i < 3; i++) cycle(1'b0, 32'h0, 1'b1, 32'h0000_000C, 1'b0, 10'h0, 32'h0);
    chk("plan_w2_data", inst2, 32'h3C01_0001);
    idle(1);

    // Abort after one stalled cycle.
    cycle(1'b0, 32'h0, 1'b1, 32'h0000_0010, 1'b0, 10'h0, 32'h0);
    cycle(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 10'h0, 32'h0);
    idle(2);

    // Load and fetch of the same word in one cycle returns the old word.
    cycle(1'b1, 32'h0000_000C, 1'b0, 32'h0, 1'b1, 10'd3, 32'hFFFF_FFFF);
    chk("plan_collide_old", inst0, 32'h3C01_0001);
    cycle(1'b1, 32'h0000_000C, 1'b0, 32'h0, 1'b0, 10'h0, 32'h0);
    chk("plan_collide_new", inst0, 32'hFFFF_FFFF);
    idle(1);

`ifdef INST_ROM_ALIGN_CHECK_EN
    cycle(1'b1, 32'h0000_000E, 1'b0, 32'h0, 1'b0, 10'h0, 32'h0);
    chk("plan_align_inst", inst0, 32'h0);
    chk("plan_align_err", {31'b0, err0}, 32'h1);
    idle(1);
`endif

    rand_cycles(600);
    do_reset();
    rand_cycles(300);
    idle(5);

    chk("drain0", exp_q0.size(), 32'h0);
    chk("drain2", exp_q2.size(), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

endmodule
